// File: rtl/fila_escrita_registradores.sv
// fila_escrita_registradores: write-back FIFO feeding the register bank write port with rs/rt bypass
module fila_escrita_registradores #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         hold,
  input  logic                         wb_valid,
  output logic                         wb_ready,
  input  logic [ADDR_W-1:0]            wb_rd,
  input  logic [DATA_W-1:0]            wb_dado,
  output logic                         RegWrite,
  output logic [ADDR_W-1:0]            rd,
  output logic [DATA_W-1:0]            dado_escrita,
  input  logic [ADDR_W-1:0]            rs_q,
  input  logic [ADDR_W-1:0]            rt_q,
  output logic                         hit_rs,
  output logic                         hit_rt,
  output logic [DATA_W-1:0]            dado_rs,
  output logic [DATA_W-1:0]            dado_rt,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] ONE = PW'(1);
  logic [ADDR_W-1:0] rd_mem  [DEPTH];
  logic [DATA_W-1:0] dat_mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] cnt;
  logic push, pop;
  assign wb_ready = (cnt < FULL) && !flush;
  assign push     = wb_valid && wb_ready && (wb_rd != '0);
  assign pop      = (cnt != '0) && !hold && !flush;
  assign count    = cnt;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head         <= '0;
      tail         <= '0;
      cnt          <= '0;
      RegWrite     <= 1'b0;
      rd           <= '0;
      dado_escrita <= '0;
    end else begin
      RegWrite <= pop;
      if (pop) begin
        rd           <= rd_mem[head];
        dado_escrita <= dat_mem[head];
      end
      if (flush) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end else begin
        head <= pop ? head + ONE : head;
        tail <= push ? tail + ONE : tail;
        cnt  <= cnt + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clock) begin
    if (push) begin
      rd_mem[tail]  <= wb_rd;
      dat_mem[tail] <= wb_dado;
    end
  end
  // Walk oldest to youngest so the youngest match overrides; issue stage is lowest priority.
  function automatic logic [DATA_W:0] look(input logic [ADDR_W-1:0] q);
    logic [DATA_W:0] r;
    logic [PW-1:0] idx;
    r = (RegWrite && rd == q) ? {1'b1, dado_escrita} : '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (CW'(k) < cnt && rd_mem[idx] == q) r = {1'b1, dat_mem[idx]};
    end
    return (q == '0) ? '0 : r;
  endfunction
  always_comb begin
    {hit_rs, dado_rs} = look(rs_q);
    {hit_rt, dado_rt} = look(rt_q);
  end
endmodule

// File: tb/tb_fila_escrita_registradores.sv
// tb_fila_escrita_registradores: randomized + directed check of the write-back queue against a queue model
module tb_fila_escrita_registradores;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic flush, hold, wb_valid, wb_ready, RegWrite, hit_rs, hit_rt;
  logic [4:0] wb_rd, rd, rs_q, rt_q;
  logic [31:0] wb_dado, dado_escrita, dado_rs, dado_rt;
  logic [2:0] count;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;
  ent_t mq[$];
  logic m_we;
  logic [4:0] m_rd;
  logic [31:0] m_d;

  fila_escrita_registradores dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .hold(hold),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_dado(wb_dado),
    .RegWrite(RegWrite), .rd(rd), .dado_escrita(dado_escrita),
    .rs_q(rs_q), .rt_q(rt_q), .hit_rs(hit_rs), .hit_rt(hit_rt),
    .dado_rs(dado_rs), .dado_rt(dado_rt), .count(count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [32:0] m_look(input logic [4:0] q);
    if (q == 0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].r == q) return {1'b1, mq[i].d};
    if (m_we && m_rd == q) return {1'b1, m_d};
    return '0;
  endfunction

  task automatic chk_all();
    logic [32:0] a, b;
    a = m_look(rs_q);
    b = m_look(rt_q);
    check("wb_ready", wb_ready, (mq.size() < 4) && !flush);
    check("count", count, mq.size());
    check("RegWrite", RegWrite, m_we);
    check("rd", rd, m_rd);
    check("dado_escrita", dado_escrita, m_d);
    check("hit_rs", hit_rs, a[32]);
    check("dado_rs", dado_rs, a[31:0]);
    check("hit_rt", hit_rt, b[32]);
    check("dado_rt", dado_rt, b[31:0]);
  endtask

  task automatic model_step();
    logic rdy;
    rdy = (mq.size() < 4) && !flush;
    if (mq.size() > 0 && !hold && !flush) begin
      m_we = 1'b1;
      m_rd = mq[0].r;
      m_d  = mq[0].d;
      void'(mq.pop_front());
    end else m_we = 1'b0;
    if (flush) mq.delete();
    if (wb_valid && rdy && wb_rd != 0) mq.push_back('{wb_rd, wb_dado});
  endtask

  task automatic cyc(input logic f, input logic h, input logic v, input logic [4:0] r,
                     input logic [31:0] d, input logic [4:0] a, input logic [4:0] b);
    @(negedge clock);
    flush = f; hold = h; wb_valid = v; wb_rd = r; wb_dado = d; rs_q = a; rt_q = b;
    #1;
    chk_all();
    model_step();
  endtask

  initial begin
    flush = 0; hold = 0; wb_valid = 0; wb_rd = 0; wb_dado = 0; rs_q = 0; rt_q = 0;
    mq.delete(); m_we = 0; m_rd = 0; m_d = 0;
    #1 reset_n = 1'b0;
    #2;
    chk_all();
    @(negedge clock);
    reset_n = 1'b1;
    // single push then drain
    cyc(0, 0, 1, 5'd4, 32'h08, 5'd4, 5'd0);
    cyc(0, 0, 0, 5'd0, 32'h0, 5'd4, 5'd0);
    cyc(0, 0, 0, 5'd0, 32'h0, 5'd4, 5'd0);
    cyc(0, 0, 0, 5'd0, 32'h0, 5'd4, 5'd0);
    // fill while held, 5th push refused, then release
    for (int i = 1; i <= 5; i++) cyc(0, 1, 1, 5'(i), 32'(i * 16), 5'd3, 5'd5);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 5'd0, 32'h0, 5'd2, 5'd4);
    // youngest match wins
    cyc(0, 1, 1, 5'd6, 32'h0F, 5'd6, 5'd6);
    cyc(0, 1, 1, 5'd6, 32'h1F, 5'd6, 5'd6);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 5'd0, 32'h0, 5'd6, 5'd0);
    // register 0 dropped
    cyc(0, 0, 1, 5'd0, 32'hFF, 5'd0, 5'd0);
    cyc(0, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
    cyc(0, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
    // flush with 3 queued
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 5'(7 + i), 32'hA0 + 32'(i), 5'd8, 5'd9);
    cyc(1, 0, 1, 5'd12, 32'hBB, 5'd8, 5'd9);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 5'd0, 32'h0, 5'd8, 5'd9);
    // reset mid-drain
    cyc(0, 1, 1, 5'd9, 32'h99, 5'd9, 5'd10);
    cyc(0, 1, 1, 5'd10, 32'hAA, 5'd9, 5'd10);
    cyc(0, 0, 0, 5'd0, 32'h0, 5'd9, 5'd10);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("rst_RegWrite", RegWrite, 1'b0);
    check("rst_count", count, 3'd0);
    check("rst_hit_rs", hit_rs, 1'b0);
    mq.delete(); m_we = 0; m_rd = 0; m_d = 0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 5'd0, 32'h0, 5'd9, 5'd10);
    // random traffic
    for (int i = 0; i < 600; i++)
      cyc(($urandom % 20) == 0, ($urandom % 3) == 0, ($urandom % 4) != 0,
          5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
